mme_top_ip: RTL and testbench
=============================

MME_TOP_IP -- requirements
Module: mme_top_ip

Interface
REQ-001 SHALL have no parameters; APB address/data 32 b, AXI address/data 32 b, AXI ID 4 b, AXI LEN 4 b (AXI3).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-high.
REQ-004 apb_if  APB slave port  psel, penable, paddr[31:0], pwrite, pwdata[31:0] in; pready, prdata[31:0], pslverr out.
REQ-005 axi_aw_if  AW master port  awid, awaddr, awlen, awsize, awburst, awvalid out; awready in.
REQ-006 axi_w_if  W master port  wid, wdata, wstrb, wlast, wvalid out; wready in.
REQ-007 axi_b_if  B master port  bid, bresp, bvalid in; bready out.
REQ-008 axi_ar_if  AR master port  arid, araddr, arlen, arsize, arburst, arvalid out; arready in.
REQ-009 axi_r_if  R master port  rid, rdata, rresp, rlast, rvalid in; rready out.

Function
REQ-010 APB: pready=1 always, pslverr=0; write takes effect in access phase (psel&penable&pwrite); prdata combinational from paddr.
REQ-011 Registers: 0x000 IP_VER RO 32'h0001_0000; 0x100 MAT_CFG RW 32 b (mat_width); 0x200 MAT_A_ADDR, 0x204 MAT_B_ADDR, 0x208 MAT_C_ADDR RW 32 b; 0x20C MME_CMD WO, reads 0; 0x210 MME_STATUS RO, bit0=done, other bits 0; unmapped reads 0, writes ignored.
REQ-012 Writing 1 to MME_CMD bit0 while IDLE SHALL start an operation and clear done; writes while busy are ignored (CMD and config).
REQ-013 Operation computes C(4x4) = A(4 x W) x B(W x 4), W = MAT_CFG; A column-major (column k = 4 words at A_ADDR+16k), B row-major (row k = 4 words at B_ADDR+16k).
REQ-014 FSM states: IDLE, RD_A_REQ, RD_A_DAT, RD_B_REQ, RD_B_DAT, MAC, WR_REQ, WR_DAT, WR_RESP, DONE.
REQ-015 IDLE -> RD_A_REQ on start with accumulators cleared to 0; if W=0 go directly to WR_REQ.
REQ-016 RD_A_REQ: araddr=A_ADDR+16k, arlen=3, arsize=2, arburst=INCR, arid=0; arvalid held until arready; RD_A_DAT: rready=1, capture 4 beats into a[0..3], leave on rlast.
REQ-017 RD_B_REQ/RD_B_DAT identical with B_ADDR+16k, capturing b[0..3].
REQ-018 MAC (1 cycle): acc[i][j] += a[i]*b[j] for all 16 (i,j), signed 32x32, low 32 bits kept (wrap-around); k++; k<W -> RD_A_REQ else WR_REQ.
REQ-019 WR_REQ: awaddr=C_ADDR, awlen=15, awsize=2, INCR, awid=0, awvalid until awready; WR_DAT: 16 beats of acc row-major (beat n = acc[n/4][n%4]), wstrb=4'hF, wlast on beat 15, each beat advances only on wvalid&wready.
REQ-020 WR_RESP: bready=1; on bvalid -> DONE; bresp ignored. DONE sets status bit0=1 and returns to IDLE next cycle; done stays 1 until next start.
REQ-021 rresp ignored; AW and W not issued concurrently (W after AW handshake).

Reset
REQ-022 On reset: FSM IDLE, all registers 0, done=0, accumulators 0, arvalid/awvalid/wvalid/rready/bready=0, wlast=0.
REQ-023 Reset mid-operation SHALL abort immediately without completing bursts.

Structure
REQ-024 Package mme_pkg SHALL hold register offsets, IP_VER constant and FSM state enum.
REQ-025 One sub-module mme_mac_array (4x4 accumulators, clear/enable inputs, a[4], b[4]) is natural; APB register file stays in top.

Verification
REQ-026 After reset read 0x000 -> 32'h0001_0000; read 0x210 -> 0.
REQ-027 Write/read-back 0x100=4, 0x200=0, 0x204=0x1000, 0x208=0x2000 -> identical values.
REQ-028 W=4, A=identity, B[k][j]=k*4+j -> memory at 0x2000 holds 0..15 row-major, status=1.
REQ-029 W=8, all A=1, all B=2 -> all 16 C words = 16.
REQ-030 W=12 and W=16 random 0..255 entries -> C words equal low 32 b of reference product; run back-to-back without reset, status re-clears on each start.
REQ-031 Random arready/rvalid/awready/wready/bvalid stalls, W=16 -> same correct C, exactly 2W read bursts and 1 write burst.

Source files
------------

// File: rtl/mme_pkg.sv
// Shared definitions for the matrix-multiply engine: register map,
// version constant, AXI burst encodings and the controller state type.
package mme_pkg;

    // Register offsets on the APB port
    localparam logic [31:0] REG_IP_VER     = 32'h0000_0000;
    localparam logic [31:0] REG_MAT_CFG    = 32'h0000_0100;
    localparam logic [31:0] REG_MAT_A_ADDR = 32'h0000_0200;
    localparam logic [31:0] REG_MAT_B_ADDR = 32'h0000_0204;
    localparam logic [31:0] REG_MAT_C_ADDR = 32'h0000_0208;
    localparam logic [31:0] REG_MME_CMD    = 32'h0000_020C;
    localparam logic [31:0] REG_MME_STATUS = 32'h0000_0210;

    localparam logic [31:0] IP_VER_VALUE   = 32'h0001_0000;

    // AXI burst shapes: 4-word reads of one A column / B row, 16-word C write
    localparam logic [3:0]  RD_BURST_LEN   = 4'd3;
    localparam logic [3:0]  WR_BURST_LEN   = 4'd15;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'd2;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_A_REQ,
        ST_RD_A_DAT,
        ST_RD_B_REQ,
        ST_RD_B_DAT,
        ST_MAC,
        ST_WR_REQ,
        ST_WR_DAT,
        ST_WR_RESP,
        ST_DONE
    } mme_state_e;

    // Address of the k-th 16-byte vector (A column or B row) above a base
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [31:0] k);
        return base + (k << 4);
    endfunction

    // Signed 32x32 multiply keeping only the low 32 bits (wrap-around)
    function automatic logic [31:0] mul_lo32(input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] p;
        p = $signed(x) * $signed(y);
        return p;
    endfunction

endpackage

// File: rtl/mme_mac_array.sv
// 4x4 array of 32-bit accumulators. Each enabled cycle performs the
// rank-1 update acc[i][j] += a[i]*b[j]; clear has priority over enable.
// Accumulators are read one at a time, row-major index i*4+j.
// rst_n is an active-high asynchronous reset in this codebase.
module mme_mac_array
    import mme_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [127:0] a_i,
    input  logic [127:0] b_i,
    input  logic [3:0]   rd_idx_i,
    output logic [31:0]  rd_data_o
);

    logic [31:0] acc_q [16];
    logic [31:0] acc_d [16];

    // Next accumulator values: hold, clear or rank-1 update
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            acc_d[n] = acc_q[n];
            if (clear_i) begin
                acc_d[n] = '0;
            end else if (en_i) begin
                acc_d[n] = acc_q[n] + mul_lo32(a_i[32*(n/4) +: 32], b_i[32*(n%4) +: 32]);
            end
        end
    end

    // Accumulator register array
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: this small register array is reset explicitly; large RAM-style memories normally are not.
            for (int n = 0; n < 16; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
            for (int n = 0; n < 16; n++) begin
                acc_q[n] <= acc_d[n];
            end
        end
    end

    assign rd_data_o = acc_q[rd_idx_i];

endmodule

// File: rtl/mme_top_ip.sv
// Matrix-multiply engine: APB register file plus an AXI3 master that
// fetches A columns / B rows, accumulates C = A x B (4x4) and writes C
// back as one 16-beat burst. rst_n is active-high asynchronous.
module mme_top_ip
    import mme_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    // APB slave
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    // AXI AW
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    // AXI W
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    // AXI B
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    // AXI AR
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    // AXI R
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    mme_state_e   state_q, state_d;
    logic [31:0]  mat_cfg_q, a_addr_q, b_addr_q, c_addr_q;
    logic         done_q;
    logic [31:0]  k_q, k_d;
    logic [1:0]   beat_q, beat_d;
    logic [3:0]   wr_cnt_q, wr_cnt_d;
    logic [127:0] a_q, b_q;
    logic         cap_a, cap_b, mac_clear, mac_en;
    logic         apb_wr, cfg_we, start;

    // IDs and responses are not used: single outstanding transaction, errors ignored
    logic unused_axi_inputs;
    assign unused_axi_inputs = ^{bid_i, bresp_i, rid_i, rresp_i};

    // APB handshake: zero wait states, never errors; config frozen while busy
    assign pready_o  = 1'b1;
    assign pslverr_o = 1'b0;
    assign apb_wr    = psel_i & penable_i & pwrite_i;
    assign cfg_we    = apb_wr & (state_q == ST_IDLE);
    assign start     = cfg_we & (paddr_i == REG_MME_CMD) & pwdata_i[0];

    // Fixed AXI burst attributes
    assign arid_o    = '0;
    assign arlen_o   = RD_BURST_LEN;
    assign arsize_o  = AXI_SIZE_WORD;
    assign arburst_o = AXI_BURST_INCR;
    assign awid_o    = '0;
    assign awaddr_o  = c_addr_q;
    assign awlen_o   = WR_BURST_LEN;
    assign awsize_o  = AXI_SIZE_WORD;
    assign awburst_o = AXI_BURST_INCR;
    assign wid_o     = '0;
    assign wstrb_o   = 4'hF;

    // Register read mux, combinational from paddr
    always_comb begin
        prdata_o = '0;
        case (paddr_i)
            REG_IP_VER:     prdata_o = IP_VER_VALUE;
            REG_MAT_CFG:    prdata_o = mat_cfg_q;
            REG_MAT_A_ADDR: prdata_o = a_addr_q;
            REG_MAT_B_ADDR: prdata_o = b_addr_q;
            REG_MAT_C_ADDR: prdata_o = c_addr_q;
            REG_MME_STATUS: prdata_o = {31'b0, done_q};
            default:        prdata_o = '0;
        endcase
    end

    // Configuration registers and sticky done flag
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mat_cfg_q <= '0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_addr_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (paddr_i)
                    REG_MAT_CFG:    mat_cfg_q <= pwdata_i;
                    REG_MAT_A_ADDR: a_addr_q  <= pwdata_i;
                    REG_MAT_B_ADDR: b_addr_q  <= pwdata_i;
                    REG_MAT_C_ADDR: c_addr_q  <= pwdata_i;
                    default: ;
                endcase
            end
            if (start) begin
                done_q <= 1'b0;
            end else if (state_q == ST_DONE) begin
                done_q <= 1'b1;
            end
        end
    end

    // Controller next-state, counters and AXI handshake outputs
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        beat_d    = beat_q;
        wr_cnt_d  = wr_cnt_q;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        araddr_o  = '0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        wlast_o   = 1'b0;
        bready_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mac_clear = 1'b1;
                    k_d       = '0;
                    beat_d    = '0;
                    wr_cnt_d  = '0;
                    state_d   = (mat_cfg_q == '0) ? ST_WR_REQ : ST_RD_A_REQ;
                end
            end
            ST_RD_A_REQ: begin
                arvalid_o = 1'b1;
                araddr_o  = vec_addr(a_addr_q, k_q);
                if (arready_i) state_d = ST_RD_A_DAT;
            end
            ST_RD_A_DAT: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    cap_a  = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (rlast_i) begin
                        beat_d  = '0;
                        state_d = ST_RD_B_REQ;
                    end
                end
            end
            ST_RD_B_REQ: begin
                arvalid_o = 1'b1;
                araddr_o  = vec_addr(b_addr_q, k_q);
                if (arready_i) state_d = ST_RD_B_DAT;
            end
            ST_RD_B_DAT: begin
                rready_o = 1'b1;
                if (rvalid_i) begin
                    cap_b  = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (rlast_i) begin
                        beat_d  = '0;
                        state_d = ST_MAC;
                    end
                end
            end
            ST_MAC: begin
                mac_en  = 1'b1;
                k_d     = k_q + 32'd1;
                state_d = (k_d < mat_cfg_q) ? ST_RD_A_REQ : ST_WR_REQ;
            end
            ST_WR_REQ: begin
                awvalid_o = 1'b1;
                if (awready_i) state_d = ST_WR_DAT;
            end
            ST_WR_DAT: begin
                wvalid_o = 1'b1;
                wlast_o  = (wr_cnt_q == 4'd15);
                if (wready_i) begin
                    wr_cnt_d = wr_cnt_q + 4'd1;
                    if (wlast_o) state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bready_o = 1'b1;
                if (bvalid_i) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, counters and captured A/B vectors
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            beat_q   <= '0;
            wr_cnt_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            wr_cnt_q <= wr_cnt_d;
            if (cap_a) a_q[32*beat_q +: 32] <= rdata_i;
            if (cap_b) b_q[32*beat_q +: 32] <= rdata_i;
        end
    end

    mme_mac_array u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (mac_clear),
        .en_i      (mac_en),
        .a_i       (a_q),
        .b_i       (b_q),
        .rd_idx_i  (wr_cnt_q),
        .rd_data_o (wdata_o)
    );

endmodule

// File: tb/tb_mme_top_ip.sv
// Self-checking bench for mme_top_ip: APB master tasks, an AXI3 slave
// memory with optional random stalls, and a plain-arithmetic matrix
// product reference.
module tb_mme_top_ip;

    localparam logic [31:0] A_IP_VER = 32'h000;
    localparam logic [31:0] A_CFG    = 32'h100;
    localparam logic [31:0] A_AADDR  = 32'h200;
    localparam logic [31:0] A_BADDR  = 32'h204;
    localparam logic [31:0] A_CADDR  = 32'h208;
    localparam logic [31:0] A_CMD    = 32'h20C;
    localparam logic [31:0] A_STATUS = 32'h210;
    localparam logic [31:0] A_BASE   = 32'h0000;
    localparam logic [31:0] B_BASE   = 32'h1000;
    localparam logic [31:0] C_BASE   = 32'h2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [3:0]  awid, awlen, wid, wstrb, bid, arid, arlen, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int tests_run    = 0;
    int tests_failed = 0;
    int ar_bursts    = 0;
    int aw_bursts    = 0;
    bit stall_en     = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] a_m [4][16];
    logic [31:0] b_m [16][4];

    always #5 clk = ~clk;

    mme_top_ip dut (
        .clk(clk), .rst_n(rst_n),
        .psel_i(psel), .penable_i(penable), .paddr_i(paddr), .pwrite_i(pwrite),
        .pwdata_i(pwdata), .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
        .awburst_o(awburst), .awvalid_o(awvalid), .awready_i(awready),
        .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
        .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
        .arburst_o(arburst), .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
        .rvalid_i(rvalid), .rready_o(rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : 32'h0;
    endfunction

    function automatic bit go();
        return stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // AXI slave memory: handshakes are sampled on the falling edge, responses
    // are updated just after the rising edge.
    initial begin : axi_slave
        logic        hs_ar, hs_r, hs_aw, hs_w, hs_b, wlast_s;
        logic [31:0] araddr_s, awaddr_s, wdata_s, r_addr, w_addr;
        logic [31:0] rq [$];
        int          r_beat, w_beat;
        bit          r_active, w_active, b_pend;
        r_active = 0; w_active = 0; b_pend = 0; r_beat = 0; w_beat = 0;
        r_addr = '0; w_addr = '0;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rid = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
        forever begin
            @(negedge clk);
            hs_ar = arvalid & arready;  araddr_s = araddr;
            hs_r  = rvalid & rready;
            hs_aw = awvalid & awready;  awaddr_s = awaddr;
            hs_w  = wvalid & wready;    wdata_s  = wdata;   wlast_s = wlast;
            hs_b  = bvalid & bready;
            @(posedge clk);
            #1;
            if (rst_n) begin
                rq.delete(); r_active = 0; w_active = 0; b_pend = 0;
            end else begin
                if (hs_ar) begin rq.push_back(araddr_s); ar_bursts++; end
                if (hs_r) begin
                    r_beat++;
                    if (r_beat == 4) r_active = 0;
                end
                if (!r_active && rq.size() > 0) begin
                    r_addr = rq.pop_front(); r_beat = 0; r_active = 1;
                end
                if (hs_aw) begin w_addr = awaddr_s; w_beat = 0; w_active = 1; aw_bursts++; end
                if (hs_w) begin
                    check("wlast position", {31'b0, wlast_s}, {31'b0, (w_beat == 15)});
                    mem[w_addr + 32'(4 * w_beat)] = wdata_s;
                    w_beat++;
                    if (w_beat == 16) begin w_active = 0; b_pend = 1; end
                end
                if (hs_b) b_pend = 0;
            end
            arready = go();
            rvalid  = r_active && go();
            rdata   = r_active ? rd_mem(r_addr + 32'(4 * r_beat)) : 32'h0;
            rlast   = r_active && (r_beat == 3);
            awready = go();
            wready  = w_active && go();
            bvalid  = b_pend && go();
        end
    end

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = addr;
        @(posedge clk); #1;
        penable = 1;
        #1;
        data = prdata;
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    // Loads A/B into memory, runs one operation and checks C, status and burst counts
    task automatic run_op(input int w, input string tag, input bit busy_write);
        logic [31:0] d, exp_c;
        int ar0, aw0;
        bit ok;
        for (int k = 0; k < w; k++) begin
            for (int i = 0; i < 4; i++) mem[A_BASE + 32'(16 * k + 4 * i)] = a_m[i][k];
            for (int j = 0; j < 4; j++) mem[B_BASE + 32'(16 * k + 4 * j)] = b_m[k][j];
        end
        for (int n = 0; n < 16; n++) mem[C_BASE + 32'(4 * n)] = 32'hDEAD_BEEF;
        apb_write(A_CFG, 32'(w));
        ar0 = ar_bursts; aw0 = aw_bursts;
        apb_write(A_CMD, 32'h1);
        apb_read(A_STATUS, d);
        check({tag, " status cleared on start"}, d, 32'h0);
        if (busy_write) begin
            apb_write(A_CFG, 32'd99);
            apb_write(A_CMD, 32'h1);
        end
        ok = 0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            apb_read(A_STATUS, d);
            if (d[0]) ok = 1;
        end
        check({tag, " completes before timeout"}, {31'b0, ok}, 32'h1);
        check({tag, " status done"}, d, 32'h1);
        apb_read(A_CFG, d);
        check({tag, " MAT_CFG unchanged while busy"}, d, 32'(w));
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_c = 32'h0;
                for (int k = 0; k < w; k++) exp_c = exp_c + a_m[i][k] * b_m[k][j];
                check($sformatf("%s C[%0d][%0d]", tag, i, j), rd_mem(C_BASE + 32'(16 * i + 4 * j)), exp_c);
            end
        end
        check({tag, " read bursts"}, 32'(ar_bursts - ar0), 32'(2 * w));
        check({tag, " write bursts"}, 32'(aw_bursts - aw0), 32'h1);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] d;
        int ar0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset handshake outputs", {26'b0, arvalid, awvalid, wvalid, rready, bready, wlast}, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;

        apb_read(A_IP_VER, d);   check("IP_VER", d, 32'h0001_0000);
        apb_read(A_STATUS, d);   check("STATUS after reset", d, 32'h0);
        apb_read(A_CFG, d);      check("MAT_CFG after reset", d, 32'h0);
        check("pready", {31'b0, pready}, 32'h1);
        check("pslverr", {31'b0, pslverr}, 32'h0);

        apb_write(A_CFG, 32'd4);
        apb_write(A_AADDR, A_BASE);
        apb_write(A_BADDR, B_BASE);
        apb_write(A_CADDR, C_BASE);
        apb_read(A_CFG, d);      check("MAT_CFG readback", d, 32'd4);
        apb_read(A_AADDR, d);    check("MAT_A_ADDR readback", d, A_BASE);
        apb_read(A_BADDR, d);    check("MAT_B_ADDR readback", d, B_BASE);
        apb_read(A_CADDR, d);    check("MAT_C_ADDR readback", d, C_BASE);
        apb_write(A_IP_VER, 32'h1234_5678);
        apb_read(A_IP_VER, d);   check("IP_VER write ignored", d, 32'h0001_0000);
        apb_write(32'h300, 32'hFFFF_FFFF);
        apb_read(32'h300, d);    check("unmapped reads 0", d, 32'h0);
        ar0 = ar_bursts;
        apb_write(A_CMD, 32'h2);
        apb_read(A_CMD, d);      check("MME_CMD reads 0", d, 32'h0);
        repeat (5) @(posedge clk);
        check("CMD bit0=0 does not start", 32'(ar_bursts - ar0), 32'h0);

        // W=4: A identity, B[k][j]=k*4+j
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) a_m[i][k] = (i == k) ? 32'h1 : 32'h0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) b_m[k][j] = 32'(k * 4 + j);
        run_op(4, "identity", 1'b1);
        check("identity C[2][3] literal", rd_mem(C_BASE + 32'd44), 32'd11);

        // W=8: all ones times all twos
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) a_m[i][k] = 32'h1;
            for (int j = 0; j < 4; j++) b_m[k][j] = 32'h2;
        end
        run_op(8, "ones_twos", 1'b0);
        check("ones_twos C[0][0] literal", rd_mem(C_BASE), 32'd16);

        // W=12 and W=16, random bytes, back to back
        for (int w = 12; w <= 16; w += 4) begin
            for (int k = 0; k < w; k++) begin
                for (int i = 0; i < 4; i++) a_m[i][k] = 32'($urandom_range(0, 255));
                for (int j = 0; j < 4; j++) b_m[k][j] = 32'($urandom_range(0, 255));
            end
            run_op(w, $sformatf("rand_w%0d", w), 1'b0);
        end

        // W=16 with random handshake stalls and full-width signed operands
        stall_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) a_m[i][k] = $urandom();
            for (int j = 0; j < 4; j++) b_m[k][j] = $urandom();
        end
        run_op(16, "stall_w16", 1'b1);
        stall_en = 1'b0;

        // Reset in the middle of an operation aborts at once
        apb_write(A_CMD, 32'h1);
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("async reset drops handshakes", {26'b0, arvalid, awvalid, wvalid, rready, bready, wlast}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        apb_read(A_STATUS, d);   check("STATUS after abort", d, 32'h0);
        apb_read(A_AADDR, d);    check("MAT_A_ADDR cleared by reset", d, 32'h0);

        // W=0 boundary: no reads, C written as zeros
        apb_write(A_AADDR, A_BASE);
        apb_write(A_BADDR, B_BASE);
        apb_write(A_CADDR, C_BASE);
        run_op(0, "w0", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
